// File: rtl/rv32e_mem_arbiter.sv
// rv32e_mem_arbiter: round-robin arbiter letting N_CORES rv32e data ports
// share a single combinational-read data RAM. One transaction in flight:
// IDLE picks and latches a winner, ISSUE drives the RAM for one cycle,
// RESP pulses the winner's ack on the following cycle.
module rv32e_mem_arbiter #(
  parameter int N_CORES = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CORES-1:0]        core_req,
  input  logic [N_CORES-1:0]        core_we,
  input  logic [N_CORES*ADDR_W-1:0] core_addr,
  input  logic [N_CORES*DATA_W-1:0] core_wdata,
  output logic [N_CORES-1:0]        core_ack,
  output logic [DATA_W-1:0]         core_rdata,
  output logic [ADDR_W-1:0]         mem_addr_bus,
  output logic [DATA_W-1:0]         mem_write_data_bus,
  output logic                      mem_write_signal,
  input  logic [DATA_W-1:0]         mem_read_data_bus,
  output logic                      busy
);
  localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [N_CORES-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;
  logic                win_we;

  // i-th candidate after the last grant, wrapping around the core count
  function automatic int rr_cand(input int last, input int i);
    return (last + i) % N_CORES;
  endfunction

  // Round-robin search starting one past the last granted core
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_addr  = '0;
    win_wdata = '0;
    win_we    = 1'b0;
    for (int i = 1; i <= N_CORES; i++) begin
      if (!win_found &&
          ((core_req >> rr_cand(int'(last_grant_q), i)) & N_CORES'(1)) != '0) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(rr_cand(int'(last_grant_q), i));
        win_addr  = ADDR_W'(core_addr >> (rr_cand(int'(last_grant_q), i) * ADDR_W));
        win_wdata = DATA_W'(core_wdata >> (rr_cand(int'(last_grant_q), i) * DATA_W));
        win_we    = ((core_we >> rr_cand(int'(last_grant_q), i)) & N_CORES'(1)) != '0;
      end
    end
  end

  // Next-state and datapath: latch in IDLE, capture read data in ISSUE, ack in RESP
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    ack_d        = '0;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          idx_d   = win_idx;
          addr_d  = win_addr;
          wdata_d = win_wdata;
          we_d    = win_we;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // writes leave the shared read register untouched
        if (!we_q) rdata_d = mem_read_data_bus;
        state_d = RESP;
      end
      RESP: begin
        ack_d        = N_CORES'(1) << idx_q;
        last_grant_d = idx_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(N_CORES - 1);
      idx_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      ack_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
    end
  end

  // RAM is only driven during ISSUE; everything else reads as zero
  assign mem_write_signal   = (state_q == ISSUE) && we_q;
  assign mem_addr_bus       = (state_q == ISSUE) ? addr_q  : '0;
  assign mem_write_data_bus = (state_q == ISSUE) ? wdata_q : '0;
  assign busy               = (state_q != IDLE);
  assign core_ack           = ack_q;
  assign core_rdata         = rdata_q;
endmodule
